// File: rtl/top.sv
// I/O address decoder with tile-slot chip selects, data-buffer control and an
// interrupt router, all configured through a simple write-only register port.
module top #(
    parameter int              ADDR_W          = 8,
    parameter int              NUM_WIN         = 4,
    parameter int              NUM_SLOTS       = 3,
    parameter int              NUM_CPU_INT     = 2,
    parameter int              NUM_CPU_NMI     = 1,
    parameter int              NUM_TILE_INT_CH = 2,
    parameter logic [7:0]      IRQ_CFG_BASE    = 8'hC0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic                                 iorq_n,
    input  logic                                 r_w_,
    input  logic                                 irq_vec_cycle,
    input  logic                                 irq_ack,
    input  logic [NUM_SLOTS-1:0]                 dev_ready_n,
    input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] tile_int_req,
    input  logic [NUM_SLOTS-1:0]                 tile_nmi_req,
    input  logic                                 cfg_clk,
    input  logic                                 cfg_we,
    input  logic [7:0]                           cfg_addr,
    input  logic [7:0]                           cfg_wdata,
    output logic                                 ready_n,
    output logic                                 io_r_w_,
    output logic                                 data_oe_n,
    output logic                                 data_dir,
    output logic                                 ff_oe_n,
    output logic [NUM_SLOTS-1:0]                 cs_n,
    output logic [NUM_CPU_INT-1:0]               cpu_int,
    output logic [NUM_CPU_NMI-1:0]               cpu_nmi,
    output logic [NUM_SLOTS-1:0]                 slot_ack
);

    localparam int         NUM_INT_SRC = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam logic [7:0] MASK_OFS    = 8'(NUM_WIN);
    localparam logic [7:0] SLOT_OFS    = 8'(2 * NUM_WIN);
    localparam logic [7:0] OP_OFS      = 8'(3 * NUM_WIN);
    localparam logic [7:0] NMI_OFS     = 8'(NUM_INT_SRC);
    localparam logic [7:0] SLOTS_B     = 8'(NUM_SLOTS);

    // cfg_clk shares the source of clk; everything is clocked by clk.
    logic unused_cfg_clk;
    assign unused_cfg_clk = cfg_clk;

    logic [7:0] base_q [NUM_WIN];
    logic [7:0] base_d [NUM_WIN];
    logic [7:0] mask_q [NUM_WIN];
    logic [7:0] mask_d [NUM_WIN];
    logic [7:0] slot_q [NUM_WIN];
    logic [7:0] slot_d [NUM_WIN];
    logic [7:0] op_q   [NUM_WIN];
    logic [7:0] op_d   [NUM_WIN];

    // Route entries keep only {enable, target[3:0]}.
    logic [4:0] int_route_q [NUM_INT_SRC];
    logic [4:0] int_route_d [NUM_INT_SRC];
    logic [4:0] nmi_route_q [NUM_SLOTS];
    logic [4:0] nmi_route_d [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]   cs_n_q, cs_n_d;
    logic [NUM_CPU_INT-1:0] cpu_int_q, cpu_int_d;
    logic [NUM_CPU_NMI-1:0] cpu_nmi_q, cpu_nmi_d;
    logic [NUM_SLOTS-1:0]   slot_ack_q, slot_ack_d;

    logic [7:0] irq_idx;
    logic       cycle_active;
    logic       win_hit;
    logic [7:0] hit_slot;
    logic       ack_found;

    assign irq_idx      = cfg_addr - IRQ_CFG_BASE;
    assign cycle_active = !iorq_n;

    always_comb begin
        for (int w = 0; w < NUM_WIN; w++) begin
            base_d[w] = base_q[w];
            mask_d[w] = mask_q[w];
            slot_d[w] = slot_q[w];
            op_d[w]   = op_q[w];
        end
        for (int i = 0; i < NUM_INT_SRC; i++) int_route_d[i] = int_route_q[i];
        for (int s = 0; s < NUM_SLOTS; s++)   nmi_route_d[s] = nmi_route_q[s];
        if (cfg_we) begin
            if (cfg_addr < IRQ_CFG_BASE) begin
                for (int w = 0; w < NUM_WIN; w++) begin
                    if (cfg_addr == 8'(w))            base_d[w] = cfg_wdata;
                    if (cfg_addr == MASK_OFS + 8'(w)) mask_d[w] = cfg_wdata;
                    if (cfg_addr == SLOT_OFS + 8'(w)) slot_d[w] = cfg_wdata;
                    if (cfg_addr == OP_OFS + 8'(w))   op_d[w]   = cfg_wdata;
                end
            end else begin
                for (int i = 0; i < NUM_INT_SRC; i++)
                    if (irq_idx == 8'(i)) int_route_d[i] = {cfg_wdata[7], cfg_wdata[3:0]};
                for (int s = 0; s < NUM_SLOTS; s++)
                    if (irq_idx == NMI_OFS + 8'(s)) nmi_route_d[s] = {cfg_wdata[7], cfg_wdata[3:0]};
            end
        end
    end

    // Scan from the top so the lowest matching window has the final say.
    always_comb begin
        win_hit  = 1'b0;
        hit_slot = 8'hFF;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if ((((addr ^ ADDR_W'(base_q[w])) & ADDR_W'(mask_q[w])) == '0) &&
                (slot_q[w] < SLOTS_B) &&
                (r_w_ ? op_q[w][0] : op_q[w][1])) begin
                win_hit  = 1'b1;
                hit_slot = slot_q[w];
            end
        end
    end

    always_comb begin
        cs_n_d = '1;
        if (cycle_active && !irq_vec_cycle && win_hit) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                if (hit_slot == 8'(s)) cs_n_d[s] = 1'b0;
        end
    end

    always_comb begin
        cpu_int_d = '0;
        for (int i = 0; i < NUM_INT_SRC; i++)
            for (int l = 0; l < NUM_CPU_INT; l++)
                if (int_route_q[i][4] && tile_int_req[i] && int_route_q[i][3:0] == 4'(l))
                    cpu_int_d[l] = 1'b1;
        cpu_nmi_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++)
            for (int l = 0; l < NUM_CPU_NMI; l++)
                if (nmi_route_q[s][4] && tile_nmi_req[s] && nmi_route_q[s][3:0] == 4'(l))
                    cpu_nmi_d[l] = 1'b1;
    end

    always_comb begin
        slot_ack_d = '0;
        ack_found  = 1'b0;
        if (irq_ack) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int c = 0; c < NUM_TILE_INT_CH; c++)
                    if (!ack_found && int_route_q[s*NUM_TILE_INT_CH+c][4] &&
                        tile_int_req[s*NUM_TILE_INT_CH+c]) begin
                        slot_ack_d[s] = 1'b1;
                        ack_found     = 1'b1;
                    end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                base_q[w] <= 8'h00;
                mask_q[w] <= 8'h00;
                slot_q[w] <= 8'hFF;
                op_q[w]   <= 8'h00;
            end
            for (int i = 0; i < NUM_INT_SRC; i++) int_route_q[i] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)   nmi_route_q[s] <= '0;
            cs_n_q     <= '1;
            cpu_int_q  <= '0;
            cpu_nmi_q  <= '0;
            slot_ack_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WIN; w++) begin
                base_q[w] <= base_d[w];
                mask_q[w] <= mask_d[w];
                slot_q[w] <= slot_d[w];
                op_q[w]   <= op_d[w];
            end
            for (int i = 0; i < NUM_INT_SRC; i++) int_route_q[i] <= int_route_d[i];
            for (int s = 0; s < NUM_SLOTS; s++)   nmi_route_q[s] <= nmi_route_d[s];
            cs_n_q     <= cs_n_d;
            cpu_int_q  <= cpu_int_d;
            cpu_nmi_q  <= cpu_nmi_d;
            slot_ack_q <= slot_ack_d;
        end
    end

    // A decoded cycle waits until its select is up; unmatched cycles complete at once.
    always_comb begin
        if (!(&cs_n_q))
            ready_n = |(~cs_n_q & dev_ready_n);
        else if (cycle_active && !irq_vec_cycle && win_hit)
            ready_n = 1'b1;
        else if (cycle_active)
            ready_n = 1'b0;
        else
            ready_n = 1'b1;
    end

    assign io_r_w_   = r_w_;
    assign data_dir  = r_w_;
    assign ff_oe_n   = !(cycle_active && irq_vec_cycle);
    assign data_oe_n = !((!(&cs_n_q)) || !ff_oe_n);
    assign cs_n      = cs_n_q;
    assign cpu_int   = cpu_int_q;
    assign cpu_nmi   = cpu_nmi_q;
    assign slot_ack  = slot_ack_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for the I/O decoder / interrupt router: inputs change on the
// falling edge, outputs are compared on the following falling edge.
module tb_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic       iorq_n;
  logic       r_w_;
  logic       irq_vec_cycle;
  logic       irq_ack;
  logic [2:0] dev_ready_n;
  logic [5:0] tile_int_req;
  logic [2:0] tile_nmi_req;
  logic       cfg_we;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       ready_n;
  logic       io_r_w_;
  logic       data_oe_n;
  logic       data_dir;
  logic       ff_oe_n;
  logic [2:0] cs_n;
  logic [1:0] cpu_int;
  logic [0:0] cpu_nmi;
  logic [2:0] slot_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  top dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .iorq_n        (iorq_n),
    .r_w_          (r_w_),
    .irq_vec_cycle (irq_vec_cycle),
    .irq_ack       (irq_ack),
    .dev_ready_n   (dev_ready_n),
    .tile_int_req  (tile_int_req),
    .tile_nmi_req  (tile_nmi_req),
    .cfg_clk       (clk),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .ready_n       (ready_n),
    .io_r_w_       (io_r_w_),
    .data_oe_n     (data_oe_n),
    .data_dir      (data_dir),
    .ff_oe_n       (ff_oe_n),
    .cs_n          (cs_n),
    .cpu_int       (cpu_int),
    .cpu_nmi       (cpu_nmi),
    .slot_ack      (slot_ack)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    addr          = 8'h00;
    iorq_n        = 1'b1;
    r_w_          = 1'b1;
    irq_vec_cycle = 1'b0;
    irq_ack       = 1'b1;
    dev_ready_n   = 3'b111;
    tile_int_req  = 6'b111111;
    tile_nmi_req  = 3'b111;
    cfg_we        = 1'b0;
    cfg_addr      = 8'h00;
    cfg_wdata     = 8'h00;

    // Writes during reset must not enable window 0 or any route.
    tick();
    cfg_write(8'h08, 8'h00);
    cfg_we = 1'b1; cfg_addr = 8'h0C; cfg_wdata = 8'hFF; tick();
    cfg_we = 1'b1; cfg_addr = 8'hC0; cfg_wdata = 8'h80; tick();
    cfg_we = 1'b0;
    tick();
    check("rst_cs_n", cs_n, 3'b111);
    check("rst_cpu_int", cpu_int, 2'b00);
    check("rst_cpu_nmi", cpu_nmi, 1'b0);
    check("rst_slot_ack", slot_ack, 3'b000);

    rst_n = 1'b1;
    tick();
    check("post_rst_cpu_int", cpu_int, 2'b00);
    check("post_rst_slot_ack", slot_ack, 3'b000);
    irq_ack = 1'b0; tile_int_req = '0; tile_nmi_req = '0;

    // Unconfigured decoder: cycle completes without select.
    addr = 8'h10; iorq_n = 1'b0; r_w_ = 1'b1;
    tick();
    check("unmapped_cs_n", cs_n, 3'b111);
    check("unmapped_ready_n", ready_n, 1'b0);
    check("unmapped_data_oe_n", data_oe_n, 1'b1);
    iorq_n = 1'b1;
    tick();
    check("idle_ready_n", ready_n, 1'b1);

    cfg_write(8'h00, 8'h10);
    cfg_write(8'h04, 8'hF0);
    cfg_write(8'h08, 8'h01);
    cfg_write(8'h0C, 8'hFF);

    addr = 8'h10; iorq_n = 1'b0; r_w_ = 1'b1; dev_ready_n = 3'b111;
    tick();
    check("rd10_cs_n", cs_n, 3'b101);
    check("rd10_ready_wait", ready_n, 1'b1);
    check("rd10_data_oe_n", data_oe_n, 1'b0);
    check("rd10_data_dir", data_dir, 1'b1);
    check("rd10_io_r_w_", io_r_w_, 1'b1);
    dev_ready_n = 3'b101;
    #1;
    check("rd10_ready_dev", ready_n, 1'b0);
    iorq_n = 1'b1;
    tick();
    check("rd10_release_cs_n", cs_n, 3'b111);
    check("rd10_release_oe", data_oe_n, 1'b1);

    addr = 8'h25; iorq_n = 1'b0;
    tick();
    check("rd25_cs_n", cs_n, 3'b111);
    check("rd25_ready_n", ready_n, 1'b0);
    addr = 8'h1F;
    tick();
    check("rd1f_cs_n", cs_n, 3'b101);
    addr = 8'h1F; r_w_ = 1'b0;
    tick();
    check("wr1f_cs_n", cs_n, 3'b101);
    check("wr1f_data_dir", data_dir, 1'b0);
    iorq_n = 1'b1;
    tick();

    // Read-only window rejects writes.
    cfg_write(8'h0C, 8'h01);
    addr = 8'h10; iorq_n = 1'b0; r_w_ = 1'b0;
    tick();
    check("ro_write_cs_n", cs_n, 3'b111);
    r_w_ = 1'b1;
    tick();
    check("ro_read_cs_n", cs_n, 3'b101);
    iorq_n = 1'b1;
    cfg_write(8'h0C, 8'hFF);

    // Window 1 catches everything on slot 2; window 0 still wins on its range.
    cfg_write(8'h05, 8'h00);
    cfg_write(8'h09, 8'h02);
    cfg_write(8'h0D, 8'hFF);
    addr = 8'h25; iorq_n = 1'b0;
    tick();
    check("w1_rd25_cs_n", cs_n, 3'b011);
    addr = 8'h1F;
    tick();
    check("prio_rd1f_cs_n", cs_n, 3'b101);
    iorq_n = 1'b1;
    cfg_write(8'h09, 8'h03);
    addr = 8'h80; iorq_n = 1'b0;
    tick();
    check("slot_oor_cs_n", cs_n, 3'b111);
    iorq_n = 1'b1;
    tick();

    // Interrupt routing.
    cfg_write(8'hC2, 8'h80);
    tile_int_req = 6'b000100;
    tick();
    check("int_route_on", cpu_int, 2'b01);
    tile_int_req = 6'b000000;
    tick();
    check("int_route_off", cpu_int, 2'b00);
    cfg_write(8'hC0, 8'hF1);
    cfg_write(8'hC1, 8'h85);
    tile_int_req = 6'b000001;
    tick();
    check("int_line1", cpu_int, 2'b10);
    tile_int_req = 6'b000010;
    tick();
    check("int_target_oor", cpu_int, 2'b00);
    tile_int_req = 6'b001000;
    tick();
    check("int_disabled_entry", cpu_int, 2'b00);
    tile_int_req = 6'b000000;

    cfg_write(8'hC6, 8'h80);
    tile_nmi_req = 3'b001;
    tick();
    check("nmi_on", cpu_nmi, 1'b1);
    tile_nmi_req = 3'b010;
    tick();
    check("nmi_unrouted", cpu_nmi, 1'b0);
    tile_nmi_req = 3'b001;

    addr = 8'h10; iorq_n = 1'b0; irq_vec_cycle = 1'b1;
    #1;
    check("vec_ff_oe_n", ff_oe_n, 1'b0);
    check("vec_data_oe_n", data_oe_n, 1'b0);
    tick();
    check("vec_cs_n", cs_n, 3'b111);
    check("vec_ff_oe_n_hold", ff_oe_n, 1'b0);
    iorq_n = 1'b1; irq_vec_cycle = 1'b0;
    #1;
    check("vec_ff_oe_n_off", ff_oe_n, 1'b1);
    tick();

    // Acknowledge picks the lowest slot with an enabled, active request.
    tile_int_req = 6'b000100; irq_ack = 1'b1;
    tick();
    check("ack_slot1", slot_ack, 3'b010);
    tile_int_req = 6'b000101;
    tick();
    check("ack_slot0", slot_ack, 3'b001);
    irq_ack = 1'b0;
    tick();
    check("ack_off", slot_ack, 3'b000);
    tile_int_req = 6'b000000;

    // Reset in the middle of a selected cycle.
    addr = 8'h10; iorq_n = 1'b0; r_w_ = 1'b1;
    tick();
    check("pre_rst_cs_n", cs_n, 3'b101);
    rst_n = 1'b0;
    tick();
    check("mid_rst_cs_n", cs_n, 3'b111);
    check("mid_rst_cpu_nmi", cpu_nmi, 1'b0);
    rst_n = 1'b1;
    tick();
    check("cfg_cleared_cs_n", cs_n, 3'b111);
    check("cfg_cleared_ready_n", ready_n, 1'b0);
    check("cfg_cleared_nmi", cpu_nmi, 1'b0);
    iorq_n = 1'b1; tile_nmi_req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
